im_loader: RTL
==============

# im_loader

Program loader for the writable instruction memory of the single-cycle RISC-V core. It accepts a byte stream (header byte with word count, then little-endian instruction bytes), assembles 32-bit words and writes them to consecutive instruction-memory addresses starting at 0. While loading, it holds the core in reset. It is the write side of the instruction memory, whose read side is the PC-indexed fetch port.

## Interface
- ADDR_BITS, 5: instruction memory address width; depth = 2**ADDR_BITS words
- WORD_WIDTH, 32: instruction width; fixed at 32, must be a multiple of 8
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle; a transfer is byte_valid && byte_ready
- im_we  output  1  instruction memory write strobe, one cycle per word
- im_addr  output  ADDR_BITS  write address
- im_wdata  output  WORD_WIDTH  write data
- busy  output  1  high in HDR, BYTES and WRITE
- done  output  1  high in DONE
- error  output  1  high in ERR
- word_count  output  ADDR_BITS+1  words written in the current or last load
- cpu_hold  output  1  drives the core's reset: high when busy or error

## Operation
- States: IDLE, HDR, BYTES, WRITE, DONE, ERR.
- IDLE: byte_ready=0. On start, go to HDR, clear word_count, clear the byte index and address.
- HDR: byte_ready=1. The first transfer is N, the word count.
  - N=0 or N > 2**ADDR_BITS: go to ERR.
  - Otherwise latch N and go to BYTES.
- BYTES: byte_ready=1. Each transfer fills lane byte_idx of the shift register, little-endian: byte 0 goes to bits [7:0]. byte_idx is 2 bits.
  - The transfer with byte_idx=3 completes the word: go to WRITE.
- WRITE: byte_ready=0. im_we=1 with im_addr = word_count[ADDR_BITS-1:0] and im_wdata = the assembled word. On exit, word_count increments.
  - Next state is DONE if word_count+1 == N, otherwise BYTES.
- DONE / ERR: byte_ready=0. Outputs hold. start goes to HDR as in IDLE.
- start in HDR, BYTES or WRITE is ignored.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.
- Reset at any point, including mid-word or mid-WRITE: return to IDLE immediately. The partially assembled word is discarded and nothing further is written.

## Timing
- Reset values: state IDLE, byte_ready 0, im_we 0, im_addr 0, im_wdata 0, busy 0, done 0, error 0, word_count 0, cpu_hold 0.
- All outputs are registered or decoded from registered state only. No combinational path from byte_valid to byte_ready.
- Throughput: 5 cycles per word (4 accept cycles + 1 WRITE), one header cycle, one start cycle.
- With byte_valid held high: the last byte is accepted in cycle k, im_we is high in k+1, and done is high from k+2.
- word_count is updated at the end of the WRITE cycle. It reads N in DONE.
- cpu_hold rises in the cycle after start is sampled and falls in the first DONE cycle.

## Structure
- Shared package `im_pkg`:
  - ADDR_BITS and WORD_WIDTH defaults, also used by the instruction memory.
  - Loader state enum type.
- Sub-module `byte_packer` (4-lane shift/assemble with byte_idx counter and word_complete flag) is natural. The FSM and counters stay in im_loader.

## Test plan
- Start, then header 0x02, then bytes 93 02 00 00 13 03 10 00 -> two writes: addr 0 = 0x00000293, addr 1 = 0x00100313. Then done=1, word_count=2, cpu_hold falls.
- Header 0x00 -> error=1, no im_we, cpu_hold stays 1. A following start and header 0x01 with bytes 6f f0 5f ff -> addr 0 = 0xff5ff06f, done=1.
- Header 0x21 (33, depth 32) -> ERR. Header 0x20 with 128 bytes -> last write at addr 31, word_count=32.
- Gaps in byte_valid (valid every third cycle) -> same written data. byte_ready stays 0 during each WRITE cycle.
- rst_n low after 2 bytes of word 1 -> IDLE, no write, all outputs at reset values. A subsequent full load of 3 words writes correctly from addr 0.
- start pulsed during BYTES -> ignored. The load completes with the original N.

Source files
------------

// File: rtl/im_pkg.sv
// Shared definitions for the instruction memory and its program loader.
//   IM_ADDR_BITS  : default instruction memory address width (depth = 2**IM_ADDR_BITS words)
//   IM_WORD_WIDTH : instruction width in bits (a multiple of 8)
//   load_state_t  : loader FSM states
package im_pkg;

    localparam int IM_ADDR_BITS  = 5;
    localparam int IM_WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_BYTES = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } load_state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler.
// The first byte after a clear lands in bits [7:0], the next in [15:8], and so on.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : drop any partial word and restart at lane 0
//   load           : data is consumed into the current lane this cycle
//   data           : incoming byte
//   word           : assembled word (lanes as last written)
//   word_complete  : high while the byte filling the last lane is being consumed
module byte_packer #(
    parameter int WORD_WIDTH = 32,
    localparam int LANES     = WORD_WIDTH / 8,
    localparam int IDX_BITS  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [7:0]            data,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_complete
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LANES - 1);

    logic [IDX_BITS-1:0] byte_idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_reg <= '0;
        end else if (clear) begin
            byte_idx_reg <= '0;
        end else if (load) begin
            // Wraps naturally back to lane 0 after the last lane.
            byte_idx_reg <= (byte_idx_reg == LAST_IDX) ? '0 : byte_idx_reg + 1'b1;
        end
    end

    assign word_complete = load && (byte_idx_reg == LAST_IDX);

    // One register per byte lane; each lane only captures when the index points at it.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_reg <= '0;
            end else if (clear) begin
                lane_reg <= '0;
            end else if (load && (byte_idx_reg == IDX_BITS'(gi))) begin
                lane_reg <= data;
            end
        end

        assign word[gi*8 +: 8] = lane_reg;
    end

endmodule

// File: rtl/im_loader.sv
// Program loader for the writable instruction memory.
// Accepts a header byte N (word count), then 4*N little-endian instruction bytes,
// and writes N words to addresses 0..N-1. The core is held in reset while loading
// and after a bad header.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start                    : begins a load (honoured in IDLE, DONE, ERR)
//   byte_valid, byte_data    : byte stream source
//   byte_ready               : loader will consume a valid byte this cycle
//   im_we, im_addr, im_wdata : instruction memory write port
//   busy, done, error        : status (HDR/BYTES/WRITE, DONE, ERR)
//   word_count               : words written in the current or last load
//   cpu_hold                 : core reset, high when busy or error
module im_loader
    import im_pkg::*;
#(
    parameter int ADDR_BITS  = IM_ADDR_BITS,
    parameter int WORD_WIDTH = IM_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  im_we,
    output logic [ADDR_BITS-1:0]  im_addr,
    output logic [WORD_WIDTH-1:0] im_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_BITS:0]    word_count,
    output logic                  cpu_hold
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    load_state_t          state_reg;
    logic [ADDR_BITS:0]   n_reg;
    logic [ADDR_BITS:0]   word_count_reg;

    logic                 can_start;
    logic                 xfer;
    logic                 hdr_bad;
    logic                 pack_load;
    logic                 pack_clear;
    logic                 word_complete;
    logic [WORD_WIDTH-1:0] packed_word;
    logic [ADDR_BITS:0]   count_inc;

    assign can_start  = (state_reg == ST_IDLE) || (state_reg == ST_DONE) || (state_reg == ST_ERR);
    // byte_ready is a pure state decode, so xfer never feeds back into byte_ready.
    assign xfer       = byte_valid && byte_ready;
    assign hdr_bad    = (byte_data == 8'd0) || (int'({24'd0, byte_data}) > DEPTH);
    assign pack_load  = xfer && (state_reg == ST_BYTES);
    assign pack_clear = start && can_start;
    assign count_inc  = word_count_reg + (ADDR_BITS + 1)'(1);

    byte_packer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (pack_clear),
        .load          (pack_load),
        .data          (byte_data),
        .word          (packed_word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            n_reg          <= '0;
            word_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_reg      <= ST_HDR;
                        word_count_reg <= '0;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        if (hdr_bad) begin
                            state_reg <= ST_ERR;
                        end else begin
                            n_reg     <= (ADDR_BITS + 1)'(byte_data);
                            state_reg <= ST_BYTES;
                        end
                    end
                end
                ST_BYTES: begin
                    if (word_complete) begin
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    word_count_reg <= count_inc;
                    state_reg      <= (count_inc == n_reg) ? ST_DONE : ST_BYTES;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = (state_reg == ST_HDR) || (state_reg == ST_BYTES);
    assign im_we      = (state_reg == ST_WRITE);
    assign im_addr    = word_count_reg[ADDR_BITS-1:0];
    assign im_wdata   = packed_word;
    assign busy       = (state_reg == ST_HDR) || (state_reg == ST_BYTES) || (state_reg == ST_WRITE);
    assign done       = (state_reg == ST_DONE);
    assign error      = (state_reg == ST_ERR);
    assign word_count = word_count_reg;
    assign cpu_hold   = busy || error;

endmodule
